jt10_adpcma_mcdec: RTL and testbench

- Time-multiplexed, multi-channel ADPCM-A nibble decoder engine for the jt10 ADPCM-A path.
- Holds a step index and a signed accumulator for each of CH channels.
- Computes the step increment arithmetically from a 49-entry step-size ROM, so no per-delta table is needed.
- Returns one PCM sample per accepted nibble through a 3-stage, cen-gated pipeline, and adds a selectable saturating accumulator mode.

---
 rtl/jt10_adpcma_mcdec.sv | 167 ++++++++++++++++
 tb/tb_jt10_adpcma_mcdec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcma_mcdec.sv
// Multi-channel ADPCM-A nibble decoder: per-channel step index and accumulator,
// three-stage cen-gated pipeline with same-channel stall and channel clear.
module jt10_adpcma_mcdec #(
    parameter int CH   = 6,
    parameter int ACCW = 12,
    parameter int SAT  = 0,
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   in_valid,
    input  logic [CW-1:0]          in_ch,
    input  logic [3:0]             in_nib,
    output logic                   in_ready,
    input  logic                   clr,
    input  logic [CW-1:0]          clr_ch,
    output logic                   out_valid,
    output logic [CW-1:0]          out_ch,
    output logic signed [ACCW-1:0] out_pcm
);
    localparam int NSLOT = 1 << CW;
    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

    function automatic logic [10:0] step_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  return 11'd16;   6'd1:  return 11'd17;   6'd2:  return 11'd19;
            6'd3:  return 11'd21;   6'd4:  return 11'd23;   6'd5:  return 11'd25;
            6'd6:  return 11'd28;   6'd7:  return 11'd31;   6'd8:  return 11'd34;
            6'd9:  return 11'd37;   6'd10: return 11'd41;   6'd11: return 11'd45;
            6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;
            6'd15: return 11'd66;   6'd16: return 11'd73;   6'd17: return 11'd80;
            6'd18: return 11'd88;   6'd19: return 11'd97;   6'd20: return 11'd107;
            6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
            6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;
            6'd27: return 11'd209;  6'd28: return 11'd230;  6'd29: return 11'd253;
            6'd30: return 11'd279;  6'd31: return 11'd307;  6'd32: return 11'd337;
            6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
            6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;
            6'd39: return 11'd658;  6'd40: return 11'd724;  6'd41: return 11'd796;
            6'd42: return 11'd876;  6'd43: return 11'd963;  6'd44: return 11'd1060;
            6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
            default: return 11'd1552;
        endcase
    endfunction

    // (2*mag+1)*step/8 replaces the classic per-delta table; capped to 11 bits
    function automatic logic [10:0] calc_inc(input logic [2:0] mag, input logic [10:0] step);
        logic [14:0] prod;
        prod = 15'({mag, 1'b1}) * 15'(step);
        if (prod[14:3] > 12'd2047) return 11'd2047;
        return prod[13:3];
    endfunction

    function automatic logic [5:0] calc_nidx(input logic [5:0] idx, input logic [2:0] mag);
        logic signed [7:0] adj;
        logic signed [7:0] t;
        case (mag)
            3'd4:    adj = 8'sd2;
            3'd5:    adj = 8'sd5;
            3'd6:    adj = 8'sd7;
            3'd7:    adj = 8'sd9;
            default: adj = -8'sd1;
        endcase
        t = $signed({2'b00, idx}) + adj;
        if (t < 0) return 6'd0;
        if (t > 48) return 6'd48;
        return t[5:0];
    endfunction

    function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] v);
        if (SAT != 0 && v[ACCW] != v[ACCW-1])
            return v[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        return v[ACCW-1:0];
    endfunction

    logic [5:0]             idx_mem [NSLOT];
    logic signed [ACCW-1:0] acc_mem [NSLOT];

    logic                   vld_p0, vld_p1, vld_p2;
    logic [CW-1:0]          ch_p0, ch_p1, ch_p2;
    logic                   sgn_p0, sgn_p1, sgn_p2;
    logic [2:0]             mag_p0, mag_p1;
    logic [5:0]             idx_p0, idx_p1, nidx_p2;
    logic signed [ACCW-1:0] acc_p0, acc_p1, acc_p2;
    logic [10:0]            step_p1, inc_p2;
    logic signed [ACCW:0]   sum_p2;
    logic signed [ACCW-1:0] nacc_p2;

    logic in_ch_ok, clr_hit, take, kill_p0, kill_p1, kill_p2;

    assign in_ch_ok = ({1'b0, in_ch} < CH_LIM);
    assign clr_hit  = clr && ({1'b0, clr_ch} < CH_LIM);
    assign kill_p0  = clr_hit && (ch_p0 == clr_ch);
    assign kill_p1  = clr_hit && (ch_p1 == clr_ch);
    assign kill_p2  = clr_hit && (ch_p2 == clr_ch);

    // no forwarding: a channel waits until its previous sample has written back
    assign in_ready = !clr
                    && !(vld_p0 && ch_p0 == in_ch)
                    && !(vld_p1 && ch_p1 == in_ch)
                    && !(vld_p2 && ch_p2 == in_ch);
    assign take = in_valid && in_ready && in_ch_ok;

    always_comb begin
        sum_p2 = '0;
        if (sgn_p2)
            sum_p2 = $signed({acc_p2[ACCW-1], acc_p2}) - $signed((ACCW+1)'(inc_p2));
        else
            sum_p2 = $signed({acc_p2[ACCW-1], acc_p2}) + $signed((ACCW+1)'(inc_p2));
        nacc_p2 = sat_acc(sum_p2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_pcm   <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                idx_mem[i] <= '0;
                acc_mem[i] <= '0;
            end
        end else if (cen) begin
            vld_p0    <= take;
            vld_p1    <= vld_p0 && !kill_p0;
            vld_p2    <= vld_p1 && !kill_p1;
            out_valid <= vld_p2 && !kill_p2;
            if (vld_p2 && !kill_p2) begin
                idx_mem[ch_p2] <= nidx_p2;
                acc_mem[ch_p2] <= nacc_p2;
                out_ch         <= ch_p2;
                out_pcm        <= nacc_p2;
            end
            if (clr_hit) begin
                idx_mem[clr_ch] <= '0;
                acc_mem[clr_ch] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            // stage 1: capture nibble and channel state
            ch_p0   <= in_ch;
            sgn_p0  <= in_nib[3];
            mag_p0  <= in_nib[2:0];
            idx_p0  <= idx_mem[in_ch];
            acc_p0  <= acc_mem[in_ch];
            // stage 2: step lookup
            ch_p1   <= ch_p0;
            sgn_p1  <= sgn_p0;
            mag_p1  <= mag_p0;
            idx_p1  <= idx_p0;
            acc_p1  <= acc_p0;
            step_p1 <= step_lut(idx_p0);
            // stage 3: increment and next index, accumulate in writeback
            ch_p2   <= ch_p1;
            sgn_p2  <= sgn_p1;
            acc_p2  <= acc_p1;
            inc_p2  <= calc_inc(mag_p1, step_p1);
            nidx_p2 <= calc_nidx(idx_p1, mag_p1);
        end
    end
endmodule

// File: tb/tb_jt10_adpcma_mcdec.sv
// Randomized bench for jt10_adpcma_mcdec: wrapping and saturating instances
// share stimulus and are compared against a transaction-level channel model.
module tb_jt10_adpcma_mcdec;
    localparam int CH   = 6;
    localparam int ACCW = 12;
    localparam int CW   = 3;

    logic clk, rst, cen, in_valid, clr;
    logic [CW-1:0] in_ch, clr_ch;
    logic [3:0] in_nib;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic [CW-1:0] out_ch0, out_ch1;
    logic signed [ACCW-1:0] out_pcm0, out_pcm1;

    jt10_adpcma_mcdec #(.CH(CH), .ACCW(ACCW), .SAT(0)) dut (
        .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .in_ch(in_ch),
        .in_nib(in_nib), .in_ready(in_ready0), .clr(clr), .clr_ch(clr_ch),
        .out_valid(out_valid0), .out_ch(out_ch0), .out_pcm(out_pcm0));

    jt10_adpcma_mcdec #(.CH(CH), .ACCW(ACCW), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .in_ch(in_ch),
        .in_nib(in_nib), .in_ready(in_ready1), .clr(clr), .clr_ch(clr_ch),
        .out_valid(out_valid1), .out_ch(out_ch1), .out_pcm(out_pcm1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int nvout   = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reference model: channel state plus at most one pending result per channel
    int STEP[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                     107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,
                     449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
    int ADJ[8]   = '{-1,-1,-1,-1,2,5,7,9};

    int idx_m [CH];
    int acc_m [2][CH];
    bit pv    [CH];
    int pret  [CH];
    int ppcm  [2][CH];
    int ncen;
    bit ev;
    int eoch, ep0, ep1;

    function automatic int wrap(input int a);
        int m, r;
        m = 1 << ACCW;
        r = a % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic int clampi(input int a, input int lo, input int hi);
        return (a < lo) ? lo : ((a > hi) ? hi : a);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            idx_m[c] = 0; acc_m[0][c] = 0; acc_m[1][c] = 0; pv[c] = 0; pret[c] = 0;
        end
        ncen = 0; ev = 0; eoch = 0; ep0 = 0; ep1 = 0;
    endtask

    function automatic bit model_ready(input int ich, input bit cl);
        if (cl) return 1'b0;
        if (ich >= CH) return 1'b1;
        return !pv[ich];
    endfunction

    task automatic model_edge(input bit tk, input int ich, input int nib, input bit cl, input int cch);
        int inc, a;
        ncen++;
        if (cl && cch < CH) begin
            idx_m[cch] = 0; acc_m[0][cch] = 0; acc_m[1][cch] = 0; pv[cch] = 0;
        end
        ev = 0;
        for (int c = 0; c < CH; c++)
            if (pv[c] && pret[c] == ncen) begin
                pv[c] = 0; ev = 1; eoch = c; ep0 = ppcm[0][c]; ep1 = ppcm[1][c];
            end
        if (tk && ich < CH) begin
            inc = ((2 * (nib % 8) + 1) * STEP[idx_m[ich]]) / 8;
            if (inc > 2047) inc = 2047;
            idx_m[ich] = clampi(idx_m[ich] + ADJ[nib % 8], 0, 48);
            for (int s = 0; s < 2; s++) begin
                a = (nib >= 8) ? acc_m[s][ich] - inc : acc_m[s][ich] + inc;
                a = (s == 1) ? clampi(a, -(1 << (ACCW-1)), (1 << (ACCW-1)) - 1) : wrap(a);
                acc_m[s][ich] = a;
                ppcm[s][ich] = a;
            end
            pv[ich] = 1;
            pret[ich] = ncen + 3;
        end
    endtask

    task automatic check_outs();
        chk("out_valid", out_valid0, ev);
        chk("out_valid_s", out_valid1, ev);
        chk("out_ch", out_ch0, eoch);
        chk("out_ch_s", out_ch1, eoch);
        chk("out_pcm", out_pcm0, ep0);
        chk("out_pcm_s", out_pcm1, ep1);
    endtask

    task automatic cyc(input bit c, input bit v, input int ich, input int nib,
                       input bit cl, input int cch, output bit accepted);
        bit rdy;
        @(negedge clk);
        cen = c; in_valid = v; in_ch = CW'(ich); in_nib = 4'(nib); clr = cl; clr_ch = CW'(cch);
        #1;
        rdy = model_ready(ich, cl);
        chk("in_ready", in_ready0, rdy);
        chk("in_ready_s", in_ready1, rdy);
        accepted = c && v && rdy;
        @(posedge clk);
        if (c) model_edge(v && rdy, ich, nib, cl, cch);
        #1;
        if (out_valid0 && c) nvout++;
        check_outs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, a);
    endtask

    task automatic feed(input int ch, input int nib);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 8 && !a; k++) cyc(1'b1, 1'b1, ch, nib, 1'b0, 0, a);
        if (!a) chk("feed_accept_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cen = 1'b0; in_valid = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_ch", out_ch0, 0);
        chk("rst_out_pcm", out_pcm0, 0);
        chk("rst_out_pcm_s", out_pcm1, 0);
        chk("rst_in_ready", in_ready0, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_w[6] = '{30, 99, 264, 655, 1581, -468};
    int exp_s[6] = '{30, 99, 264, 655, 1581, 2047};

    initial begin
        bit a;
        int stalls, v0;
        rst = 1'b1; cen = 1'b0; in_valid = 1'b0; in_ch = '0; in_nib = '0; clr = 1'b0; clr_ch = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        feed(0, 7); idle(3);
        chk("ch0_first", out_pcm0, 30);
        feed(0, 0); idle(3);
        chk("ch0_second", out_pcm0, 34);

        feed(2, 8); idle(3);
        chk("ch2_neg", out_pcm0, -2);
        chk("ch2_neg_ch", out_ch0, 2);
        feed(2, 0); idle(3);
        chk("ch2_idx_floor", out_pcm0, 0);

        for (int i = 0; i < 6; i++) begin
            feed(1, 7); idle(3);
            chk("ch1_wrap_seq", out_pcm0, exp_w[i]);
            chk("ch1_sat_seq", out_pcm1, exp_s[i]);
        end
        feed(1, 8); idle(3);
        chk("ch1_sat_down", out_pcm1, 1853);
        chk("ch1_wrap_down", out_pcm0, -662);

        cyc(1'b1, 1'b1, 0, 1, 1'b0, 0, a);
        chk("b2b_first", a, 1);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 0, 2, 1'b0, 0, a);
            if (a) break;
            stalls++;
        end
        chk("b2b_stall", stalls, 3);
        idle(3);

        v0 = nvout;
        for (int c = 0; c < CH; c++) begin
            cyc(1'b1, 1'b1, c, int'($urandom_range(0, 15)), 1'b0, 0, a);
            chk("ilv_accept", a, 1);
        end
        idle(4);
        chk("ilv_strobes", nvout - v0, 6);

        cyc(1'b1, 1'b0, 0, 0, 1'b1, 3, a);
        feed(3, 7); idle(1);
        v0 = nvout;
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 3, a);
        idle(4);
        chk("clr_cancel", nvout - v0, 0);
        feed(3, 7); idle(3);
        chk("clr_then_ch3", out_pcm0, 30);
        chk("clr_then_ch3_ch", out_ch0, 3);

        for (int i = 0; i < 2400; i++) begin
            if (i == 1200) do_reset();
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)), a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
